// File: rtl/pack_i32_stream.sv
// rtl/pack_i32_stream.sv - streaming LEB128 encoder, one 32-bit word in, one byte per cycle out
module pack_i32_stream #(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic [2:0]  out_len
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  len_q, len_d;
    logic        word_last;

    // Drop one 7-bit group; signed mode keeps the sign so the tail stays all-ones for negatives.
    function automatic logic [31:0] shr7(input logic [31:0] v);
        if (SIGNED) begin
            shr7 = {{7{v[31]}}, v[31:7]};
        end else begin
            shr7 = {7'b0, v[31:7]};
        end
    endfunction

    // True when the low 7 bits of v already carry everything left to encode.
    function automatic logic ends_here(input logic [31:0] v);
        logic [31:0] rest;
        rest = shr7(v);
        if (SIGNED) begin
            ends_here = ((rest == 32'h0000_0000) && !v[6]) ||
                        ((rest == 32'hFFFF_FFFF) && v[6]);
        end else begin
            ends_here = (rest == 32'h0000_0000);
        end
    endfunction

    // Minimal byte count of a word; after four groups the fifth byte always ends it.
    function automatic logic [2:0] calc_len(input logic [31:0] v);
        logic [31:0] s;
        logic        done;
        s        = v;
        done     = 1'b0;
        calc_len = 3'd1;
        for (int i = 0; i < 4; i++) begin
            if (!done) begin
                if (ends_here(s)) begin
                    done = 1'b1;
                end else begin
                    calc_len = calc_len + 3'd1;
                    s        = shr7(s);
                end
            end
        end
    endfunction

    // Termination of the byte currently presented.
    always_comb begin
        word_last = (idx_q == 3'd4) || ends_here(shift_q);
    end

    // Next-state, load/shift control and output decode.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        len_d     = len_q;
        out_valid = (state_q == EMIT);
        out_last  = (state_q == EMIT) && word_last;
        out_data  = (state_q == EMIT) ? {~word_last, shift_q[6:0]} : 8'h00;
        out_len   = (state_q == EMIT) ? len_q : 3'd0;
        in_ready  = (state_q == IDLE) || ((state_q == EMIT) && out_ready && word_last);

        if (in_valid && in_ready) begin
            state_d = EMIT;
            shift_d = in_data;
            idx_d   = 3'd0;
            len_d   = calc_len(in_data);
        end else if ((state_q == EMIT) && out_ready) begin
            if (word_last) begin
                state_d = IDLE;
            end else begin
                shift_d = shr7(shift_q);
                idx_d   = idx_q + 3'd1;
            end
        end
    end

    // State registers; an asynchronous reset discards any word in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= 32'h0000_0000;
            idx_q   <= 3'd0;
            len_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_pack_i32_stream.sv
// tb/tb_pack_i32_stream.sv - self-checking bench for pack_i32_stream in signed and unsigned modes
module tb_pack_i32_stream;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0][31:0] in_data;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0][7:0]  out_data;
    logic [1:0]       out_last;
    logic [1:0][2:0]  out_len;

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_bytes[$];
    logic [7:0] obs_bytes[$];
    logic [2:0] obs_len[$];
    logic       obs_last[$];

    logic [31:0] tv_val[13] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'd63, 32'd64, 32'hFFFF_FFC0,
                                32'hFFFF_FFBF, 32'd624485, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'd127, 32'd128, 32'hFFFF_FFFF};
    bit          tv_sgn[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    pack_i32_stream #(.SIGNED(1'b0)) u_unsigned (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .out_len(out_len[0])
    );

    pack_i32_stream #(.SIGNED(1'b1)) u_signed (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .out_len(out_len[1])
    );

    // Reference: 64-bit integer arithmetic, peel 7 bits at a time until the remainder is pure sign.
    task automatic model_encode(input bit sgn, input logic [31:0] v);
        longint val;
        longint rest;
        int     b7;
        bit     fin;
        logic [7:0] b;
        exp_bytes.delete();
        val = sgn ? longint'($signed(v)) : longint'(v);
        fin = 1'b0;
        for (int n = 0; n < 8 && !fin; n++) begin
            rest = val >>> 7;
            b7   = int'(val & 64'd127);
            fin  = sgn ? ((rest == 0 && b7 < 64) || (rest == -1 && b7 >= 64)) : (rest == 0);
            b    = {~fin, b7[6:0]};
            exp_bytes.push_back(b);
            val  = rest;
        end
    endtask

    function automatic string fmt_obs();
        string s = "";
        foreach (obs_bytes[i]) s = {s, $sformatf("%02h/%0d/%0d ", obs_bytes[i], obs_len[i], obs_last[i])};
        return s;
    endfunction

    function automatic string fmt_exp();
        string s = "";
        foreach (exp_bytes[i]) s = {s, $sformatf("%02h/%0d/%0d ", exp_bytes[i], exp_bytes.size(), i == exp_bytes.size() - 1)};
        return s;
    endfunction

    // Feed one word with out_ready held high and record every byte presented.
    task automatic collect(input int w, input logic [31:0] v, output bit ok);
        ok = 1'b0;
        obs_bytes.delete();
        obs_len.delete();
        obs_last.delete();
        @(negedge clk);
        for (int k = 0; k < 20 && !in_ready[w]; k++) @(negedge clk);
        in_valid[w]  = 1'b1;
        in_data[w]   = v;
        out_ready[w] = 1'b1;
        @(negedge clk);
        in_valid[w] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid[w]) begin
                obs_bytes.push_back(out_data[w]);
                obs_len.push_back(out_len[w]);
                obs_last.push_back(out_last[w]);
                if (out_last[w]) begin
                    ok = 1'b1;
                    break;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 2'b11;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            checks++;
            if ({in_ready[w], out_valid[w], out_data[w], out_last[w], out_len[w]} !== {1'b1, 1'b0, 8'h00, 1'b0, 3'd0})
                $display("FAIL reset_state dut%0d: got rdy=%b vld=%b data=%02h last=%b len=%0d, want rdy=1 vld=0 data=00 last=0 len=0",
                         w, in_ready[w], out_valid[w], out_data[w], out_last[w], out_len[w]);
            else passes++;
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        bit ok;
        for (int t = 0; t < 13; t++) begin
            model_encode(tv_sgn[t], tv_val[t]);
            collect(tv_sgn[t] ? 1 : 0, tv_val[t], ok);
            checks++;
            if (!ok || fmt_obs() != fmt_exp())
                $display("FAIL vector signed=%0d word=%08h: got [%s] done=%0d, want [%s]",
                         tv_sgn[t], tv_val[t], fmt_obs(), ok, fmt_exp());
            else passes++;
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] v;
        for (int t = 0; t < 60; t++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = ~v + 32'd1;
            model_encode(t[0], v);
            collect(t[0] ? 1 : 0, v, ok);
            checks++;
            if (!ok || fmt_obs() != fmt_exp())
                $display("FAIL random signed=%0d word=%08h: got [%s] done=%0d, want [%s]",
                         t[0], v, fmt_obs(), ok, fmt_exp());
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] want[3] = '{8'hE5, 8'h8E, 8'h26};
        bit         pat[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bit         r;
        int         n = 0;
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_data[1]  = 32'd624485;
        @(negedge clk);
        in_valid[1] = 1'b0;
        for (int step = 0; step < 12 && n < 3; step++) begin
            r = (step < 6) ? pat[step] : 1'b1;
            out_ready[1] = r;
            #1;
            checks++;
            if ({out_valid[1], out_data[1], out_last[1], out_len[1], in_ready[1]} !==
                {1'b1, want[n], n == 2, 3'd3, r && (n == 2)})
                $display("FAIL backpressure step%0d: got vld=%b data=%02h last=%b len=%0d rdy=%b, want vld=1 data=%02h last=%0d len=3 rdy=%0d",
                         step, out_valid[1], out_data[1], out_last[1], out_len[1], in_ready[1], want[n], n == 2, r && (n == 2));
            else passes++;
            if (r) n++;
            @(negedge clk);
        end
        checks++;
        if (n != 3 || out_valid[1] !== 1'b0)
            $display("FAIL backpressure_done: got bytes=%0d vld=%b, want bytes=3 vld=0", n, out_valid[1]);
        else passes++;
        out_ready[1] = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_data[1]  = 32'd64;
        @(negedge clk);
        in_data[1] = 32'd1;
        checks++;
        if ({out_valid[1], out_data[1], out_last[1], in_ready[1]} !== {1'b1, 8'hC0, 1'b0, 1'b0})
            $display("FAIL b2b_byte0: got vld=%b data=%02h last=%b rdy=%b, want vld=1 data=c0 last=0 rdy=0",
                     out_valid[1], out_data[1], out_last[1], in_ready[1]);
        else passes++;
        @(negedge clk);
        checks++;
        if ({out_valid[1], out_data[1], out_last[1], out_len[1], in_ready[1]} !== {1'b1, 8'h00, 1'b1, 3'd2, 1'b1})
            $display("FAIL b2b_byte1: got vld=%b data=%02h last=%b len=%0d rdy=%b, want vld=1 data=00 last=1 len=2 rdy=1",
                     out_valid[1], out_data[1], out_last[1], out_len[1], in_ready[1]);
        else passes++;
        @(negedge clk);
        in_valid[1] = 1'b0;
        checks++;
        if ({out_valid[1], out_data[1], out_last[1], out_len[1]} !== {1'b1, 8'h01, 1'b1, 3'd1})
            $display("FAIL b2b_byte2: got vld=%b data=%02h last=%b len=%0d, want vld=1 data=01 last=1 len=1",
                     out_valid[1], out_data[1], out_last[1], out_len[1]);
        else passes++;
        @(negedge clk);
        checks++;
        if (out_valid[1] !== 1'b0)
            $display("FAIL b2b_idle: got vld=%b, want vld=0", out_valid[1]);
        else passes++;
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        @(negedge clk);
        in_valid[1] = 1'b1;
        in_data[1]  = 32'h8000_0000;
        @(negedge clk);
        in_valid[1] = 1'b0;
        checks++;
        if ({out_valid[1], out_data[1]} !== {1'b1, 8'h80})
            $display("FAIL midreset_first: got vld=%b data=%02h, want vld=1 data=80", out_valid[1], out_data[1]);
        else passes++;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid[1], out_data[1], out_len[1]} !== {1'b0, 8'h00, 3'd0})
            $display("FAIL midreset_async: got vld=%b data=%02h len=%0d, want vld=0 data=00 len=0",
                     out_valid[1], out_data[1], out_len[1]);
        else passes++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({in_ready[1], out_valid[1]} !== 2'b10)
                $display("FAIL midreset_after: got rdy=%b vld=%b, want rdy=1 vld=0", in_ready[1], out_valid[1]);
            else passes++;
        end
        collect(1, 32'd5, ok);
        checks++;
        if (!ok || fmt_obs() != "05/1/1 ")
            $display("FAIL midreset_next: got [%s] done=%0d, want [05/1/1 ]", fmt_obs(), ok);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
